// File: rtl/cms_heap_feeder.sv
// cms_heap_feeder: admission control in front of the top-K heap.
// Non-zero estimates go straight in while the heap has room. Once it is full,
// an estimate replaces the exposed minimum only if it is strictly larger.
module cms_heap_feeder #(
    parameter int unsigned KEY_WIDTH   = 32,
    parameter int unsigned VALUE_WIDTH = 32,
    parameter int unsigned HEAP_DEPTH  = 32,
    parameter int unsigned OCC_WIDTH   = 6
) (
    input  logic                   ap_clk,
    input  logic                   ap_reset,
    input  logic [KEY_WIDTH-1:0]   est_key,
    input  logic [VALUE_WIDTH-1:0] est_value,
    input  logic                   est_valid,
    output logic                   est_ready,
    output logic [KEY_WIDTH-1:0]   heap_key_in,
    output logic [VALUE_WIDTH-1:0] heap_value_in,
    output logic                   heap_kv_in_valid,
    output logic                   heap_kv_out_ready,
    input  logic [KEY_WIDTH-1:0]   heap_key_out,
    input  logic [VALUE_WIDTH-1:0] heap_value_out,
    input  logic                   heap_kv_out_valid,
    output logic [OCC_WIDTH-1:0]   occupancy,
    output logic [31:0]            insert_cnt,
    output logic [31:0]            evict_cnt,
    output logic [31:0]            drop_cnt
);

    localparam int unsigned CNT_WIDTH  = 32;
    localparam int unsigned WAIT_WIDTH = 2;
    // Three POP_WAIT cycles: load 2, count down to 0.
    localparam logic [WAIT_WIDTH-1:0] WAIT_LOAD = WAIT_WIDTH'(2);

    typedef enum logic [2:0] {
        IDLE, DECIDE, WAIT_MIN, POP, POP_WAIT, INSERT
    } state_t;

    state_t                 state;
    state_t                 next_state;
    logic [KEY_WIDTH-1:0]   hold_key;
    logic [VALUE_WIDTH-1:0] hold_value;
    logic                   min_valid_q;
    logic [VALUE_WIDTH-1:0] min_value_q;
    logic [WAIT_WIDTH-1:0]  wait_cnt;

    logic                   next_est_ready;
    logic                   next_kv_in_valid;
    logic                   next_kv_out_ready;
    logic [KEY_WIDTH-1:0]   next_key_in;
    logic [VALUE_WIDTH-1:0] next_value_in;
    logic                   do_capture;
    logic                   do_drop;
    logic                   do_pop;
    logic                   do_insert;

    // The heap minimum key is not needed for the admission decision.
    logic unused_heap_key;
    assign unused_heap_key = ^heap_key_out;

    // State register.
    always_ff @(posedge ap_clk or posedge ap_reset) begin
        if (ap_reset) state <= IDLE;
        else          state <= next_state;
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (est_valid && est_ready) next_state = DECIDE;
            DECIDE: begin
                if (hold_value == '0)                          next_state = IDLE;
                else if (occupancy < OCC_WIDTH'(HEAP_DEPTH))   next_state = INSERT;
                else                                           next_state = WAIT_MIN;
            end
            WAIT_MIN: if (min_valid_q) next_state = (hold_value > min_value_q) ? POP : IDLE;
            POP:      next_state = POP_WAIT;
            POP_WAIT: if (wait_cnt == '0) next_state = INSERT;
            INSERT:   next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // Output decode: next output values from the next state, plus per-cycle events.
    always_comb begin
        next_est_ready    = 1'b0;
        next_kv_in_valid  = 1'b0;
        next_kv_out_ready = 1'b0;
        next_key_in       = '0;
        next_value_in     = '0;
        do_capture        = 1'b0;
        do_drop           = 1'b0;
        do_pop            = 1'b0;
        do_insert         = 1'b0;
        next_est_ready    = (next_state == IDLE);
        next_kv_out_ready = (next_state == POP);
        if (next_state == INSERT) begin
            next_kv_in_valid = 1'b1;
            next_key_in      = hold_key;
            next_value_in    = hold_value;
        end
        do_capture = (state == IDLE) && est_valid && est_ready;
        do_drop    = ((state == DECIDE) && (hold_value == '0)) ||
                     ((state == WAIT_MIN) && min_valid_q && !(hold_value > min_value_q));
        do_pop     = (state == POP);
        do_insert  = (state == INSERT);
    end

    // Registered outputs toward upstream and the heap.
    always_ff @(posedge ap_clk or posedge ap_reset) begin
        if (ap_reset) begin
            est_ready         <= 1'b0;
            heap_kv_in_valid  <= 1'b0;
            heap_kv_out_ready <= 1'b0;
            heap_key_in       <= '0;
            heap_value_in     <= '0;
        end else begin
            est_ready         <= next_est_ready;
            heap_kv_in_valid  <= next_kv_in_valid;
            heap_kv_out_ready <= next_kv_out_ready;
            heap_key_in       <= next_key_in;
            heap_value_in     <= next_value_in;
        end
    end

    // Hold registers, registered heap minimum and the pop bubble timer.
    always_ff @(posedge ap_clk or posedge ap_reset) begin
        if (ap_reset) begin
            hold_key    <= '0;
            hold_value  <= '0;
            min_valid_q <= 1'b0;
            min_value_q <= '0;
            wait_cnt    <= '0;
        end else begin
            if (do_capture) begin
                hold_key   <= est_key;
                hold_value <= est_value;
            end
            min_valid_q <= heap_kv_out_valid;
            min_value_q <= heap_value_out;
            if (do_pop)                                     wait_cnt <= WAIT_LOAD;
            else if ((state == POP_WAIT) && (wait_cnt != '0)) wait_cnt <= wait_cnt - WAIT_WIDTH'(1);
        end
    end

    // Occupancy and saturating statistics counters.
    always_ff @(posedge ap_clk or posedge ap_reset) begin
        if (ap_reset) begin
            occupancy  <= '0;
            insert_cnt <= '0;
            evict_cnt  <= '0;
            drop_cnt   <= '0;
        end else begin
            if (do_pop)         occupancy <= occupancy - OCC_WIDTH'(1);
            else if (do_insert) occupancy <= occupancy + OCC_WIDTH'(1);
            if (do_insert && (insert_cnt != '1)) insert_cnt <= insert_cnt + CNT_WIDTH'(1);
            if (do_pop && (evict_cnt != '1))     evict_cnt  <= evict_cnt + CNT_WIDTH'(1);
            if (do_drop && (drop_cnt != '1))     drop_cnt   <= drop_cnt + CNT_WIDTH'(1);
        end
    end

    // Occupancy must stay within [0, HEAP_DEPTH].
    occ_no_underflow: assert property (@(posedge ap_clk) disable iff (ap_reset)
        (state == POP) |-> (occupancy != '0));
    occ_no_overflow: assert property (@(posedge ap_clk) disable iff (ap_reset)
        (state == INSERT) |-> (occupancy < OCC_WIDTH'(HEAP_DEPTH)));

endmodule

// File: tb/tb_cms_heap_feeder.sv
// Directed bench for cms_heap_feeder; the bench plays the heap's minimum port.
module tb_cms_heap_feeder;

    localparam int unsigned KW  = 32;
    localparam int unsigned VW  = 32;
    localparam int unsigned HD  = 4;
    localparam int unsigned OW  = 6;

    logic          ap_clk;
    logic          ap_reset;
    logic [KW-1:0] est_key;
    logic [VW-1:0] est_value;
    logic          est_valid;
    logic          est_ready;
    logic [KW-1:0] heap_key_in;
    logic [VW-1:0] heap_value_in;
    logic          heap_kv_in_valid;
    logic          heap_kv_out_ready;
    logic [KW-1:0] heap_key_out;
    logic [VW-1:0] heap_value_out;
    logic          heap_kv_out_valid;
    logic [OW-1:0] occupancy;
    logic [31:0]   insert_cnt;
    logic [31:0]   evict_cnt;
    logic [31:0]   drop_cnt;

    int passed = 0;
    int total  = 0;

    cms_heap_feeder #(
        .KEY_WIDTH(KW), .VALUE_WIDTH(VW), .HEAP_DEPTH(HD), .OCC_WIDTH(OW)
    ) dut (
        .ap_clk(ap_clk), .ap_reset(ap_reset),
        .est_key(est_key), .est_value(est_value), .est_valid(est_valid), .est_ready(est_ready),
        .heap_key_in(heap_key_in), .heap_value_in(heap_value_in),
        .heap_kv_in_valid(heap_kv_in_valid), .heap_kv_out_ready(heap_kv_out_ready),
        .heap_key_out(heap_key_out), .heap_value_out(heap_value_out),
        .heap_kv_out_valid(heap_kv_out_valid),
        .occupancy(occupancy), .insert_cnt(insert_cnt), .evict_cnt(evict_cnt), .drop_cnt(drop_cnt)
    );

    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Present one estimate for exactly one clock; caller is at a negedge in IDLE.
    task automatic offer(input logic [KW-1:0] k, input logic [VW-1:0] v);
        check("offer_ready", 32'(est_ready), 32'd1);
        est_key   = k;
        est_value = v;
        est_valid = 1'b1;
        @(negedge ap_clk);
        est_valid = 1'b0;
    endtask

    // Not-full insert: strobe two cycles after accept, ready again at three.
    task automatic feed_insert(input logic [KW-1:0] k, input logic [VW-1:0] v, input int occ);
        offer(k, v);
        check("ins_decide_nowrite", 32'(heap_kv_in_valid), 32'd0);
        check("ins_decide_value0", heap_value_in, 32'd0);
        @(negedge ap_clk);
        check("ins_strobe", 32'(heap_kv_in_valid), 32'd1);
        check("ins_key", heap_key_in, k);
        check("ins_value", heap_value_in, v);
        @(negedge ap_clk);
        check("ins_strobe_single", 32'(heap_kv_in_valid), 32'd0);
        check("ins_ready_back", 32'(est_ready), 32'd1);
        check("ins_occ", 32'(occupancy), 32'(occ));
    endtask

    initial begin
        int  accepted;
        int  pops;
        int  writes;
        int  since_pop;
        int  settle;
        logic v_d1;
        logic v_d2;
        logic found;

        ap_reset          = 1'b1;
        est_valid         = 1'b0;
        est_key           = '0;
        est_value         = '0;
        heap_key_out      = '0;
        heap_value_out    = '0;
        heap_kv_out_valid = 1'b0;
        repeat (2) @(negedge ap_clk);

        // Reset state
        check("rst_est_ready", 32'(est_ready), 32'd0);
        check("rst_in_valid", 32'(heap_kv_in_valid), 32'd0);
        check("rst_out_ready", 32'(heap_kv_out_ready), 32'd0);
        check("rst_occ", 32'(occupancy), 32'd0);
        check("rst_insert", insert_cnt, 32'd0);
        check("rst_drop", drop_cnt, 32'd0);
        ap_reset = 1'b0;
        @(negedge ap_clk);
        check("ready_after_reset", 32'(est_ready), 32'd1);

        // Zero estimate while not full is dropped in DECIDE
        offer(32'h0000_0099, 32'd0);
        check("zero_nowrite_decide", 32'(heap_kv_in_valid), 32'd0);
        @(negedge ap_clk);
        check("zero_nowrite", 32'(heap_kv_in_valid), 32'd0);
        check("zero_ready_back", 32'(est_ready), 32'd1);
        check("zero_drop", drop_cnt, 32'd1);
        check("zero_occ", 32'(occupancy), 32'd0);

        // Fill the heap
        feed_insert(32'h0000_000A, 32'd10, 1);
        feed_insert(32'h0000_000B, 32'd20, 2);
        feed_insert(32'h0000_000C, 32'd30, 3);
        feed_insert(32'h0000_000D, 32'd40, 4);
        check("fill_insert_cnt", insert_cnt, 32'd4);
        check("fill_evict_cnt", evict_cnt, 32'd0);

        // Full replace: minimum 10 held invalid for a while, then exposed
        heap_key_out      = 32'h0000_000A;
        heap_value_out    = 32'd10;
        heap_kv_out_valid = 1'b0;
        offer(32'h0000_000E, 32'd50);
        for (int i = 0; i < 6; i++) begin
            @(negedge ap_clk);
            check("rep_wait_no_pop", 32'(heap_kv_out_ready), 32'd0);
        end
        heap_kv_out_valid = 1'b1;
        @(negedge ap_clk);
        check("rep_pop_not_yet", 32'(heap_kv_out_ready), 32'd0);
        @(negedge ap_clk);
        check("rep_pop", 32'(heap_kv_out_ready), 32'd1);
        heap_kv_out_valid = 1'b0;
        @(negedge ap_clk);
        check("rep_pop_single", 32'(heap_kv_out_ready), 32'd0);
        check("rep_occ_mid", 32'(occupancy), 32'd3);
        check("rep_evict", evict_cnt, 32'd1);
        for (int i = 0; i < 2; i++) begin
            @(negedge ap_clk);
            check("rep_bubble_nowrite", 32'(heap_kv_in_valid), 32'd0);
        end
        @(negedge ap_clk);
        check("rep_write", 32'(heap_kv_in_valid), 32'd1);
        check("rep_write_value", heap_value_in, 32'd50);
        check("rep_write_key", heap_key_in, 32'h0000_000E);
        @(negedge ap_clk);
        check("rep_occ", 32'(occupancy), 32'd4);
        check("rep_insert_cnt", insert_cnt, 32'd5);

        // Tie and smaller estimates against minimum 10 are dropped
        heap_kv_out_valid = 1'b1;
        @(negedge ap_clk);
        offer(32'h0000_0010, 32'd10);
        check("tie_no_pop_a", 32'(heap_kv_out_ready), 32'd0);
        @(negedge ap_clk);
        check("tie_no_pop_b", 32'(heap_kv_out_ready), 32'd0);
        @(negedge ap_clk);
        check("tie_ready_back", 32'(est_ready), 32'd1);
        check("tie_nowrite", 32'(heap_kv_in_valid), 32'd0);
        offer(32'h0000_0011, 32'd5);
        @(negedge ap_clk);
        check("small_no_pop", 32'(heap_kv_out_ready), 32'd0);
        @(negedge ap_clk);
        check("small_ready_back", 32'(est_ready), 32'd1);
        check("drop_total", drop_cnt, 32'd3);
        check("drop_occ", 32'(occupancy), 32'd4);

        // Back-to-back estimates of 100 into the full heap
        accepted  = 0;
        pops      = 0;
        writes    = 0;
        since_pop = 100;
        settle    = 0;
        v_d1      = heap_kv_out_valid;
        v_d2      = heap_kv_out_valid;
        est_key   = 32'h0000_0100;
        est_value = 32'd100;
        est_valid = 1'b1;
        for (int cyc = 0; cyc < 400 && writes < 6; cyc++) begin
            if (accepted == 6) est_valid = 1'b0;
            else est_key = 32'h0000_0100 + 32'(accepted);
            since_pop++;
            if (heap_kv_out_ready) begin
                check("b2b_pop_after_valid", 32'(v_d2), 32'd1);
                check("b2b_pop_spacing", 32'(since_pop >= 5), 32'd1);
                pops++;
                since_pop = 0;
                heap_kv_out_valid = 1'b0;
            end
            if (heap_kv_in_valid) begin
                check("b2b_write_after_pop", 32'(since_pop), 32'd4);
                check("b2b_write_value", heap_value_in, 32'd100);
                writes++;
                settle = 2;
            end else if (settle > 0) begin
                settle--;
                if (settle == 0) heap_kv_out_valid = 1'b1;
            end
            if (est_valid && est_ready) accepted++;
            v_d2 = v_d1;
            v_d1 = heap_kv_out_valid;
            @(negedge ap_clk);
        end
        est_valid = 1'b0;
        check("b2b_writes", 32'(writes), 32'd6);
        check("b2b_pops", 32'(pops), 32'd6);
        check("b2b_accepted", 32'(accepted), 32'd6);
        check("b2b_evict_cnt", evict_cnt, 32'd7);
        check("b2b_insert_cnt", insert_cnt, 32'd11);
        check("b2b_occ", 32'(occupancy), 32'd4);

        // Asynchronous reset while in POP_WAIT
        heap_kv_out_valid = 1'b1;
        @(negedge ap_clk);
        offer(32'h0000_0200, 32'd100);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge ap_clk);
            if (heap_kv_out_ready) found = 1'b1;
        end
        check("ar_pop_seen", 32'(found), 32'd1);
        @(negedge ap_clk);
        #2 ap_reset = 1'b1;
        #1;
        check("ar_est_ready", 32'(est_ready), 32'd0);
        check("ar_out_ready", 32'(heap_kv_out_ready), 32'd0);
        check("ar_in_valid", 32'(heap_kv_in_valid), 32'd0);
        check("ar_value_in", heap_value_in, 32'd0);
        check("ar_occ", 32'(occupancy), 32'd0);
        check("ar_insert", insert_cnt, 32'd0);
        check("ar_evict", evict_cnt, 32'd0);
        check("ar_drop", drop_cnt, 32'd0);
        @(negedge ap_clk);
        ap_reset = 1'b0;
        @(negedge ap_clk);
        check("ar_ready_first_clk", 32'(est_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge ap_clk);
            check("ar_no_stale_write", 32'(heap_kv_in_valid), 32'd0);
        end
        check("ar_occ_after", 32'(occupancy), 32'd0);
        check("ar_insert_after", insert_cnt, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
